apb_reg_slave: RTL

APB_REG_SLAVE -- requirements
Module: apb_reg_slave

---
 rtl/apb_reg_slave.sv | 81 ++++++++
 1 files changed

// File: rtl/apb_reg_slave.sv
// apb_reg_slave: APB register slave with CTRL, STATUS and six SCRATCH registers and programmable wait states
module apb_reg_slave #(
    parameter int PADDR_WIDTH    = 8,
    parameter int APB_DATA_WIDTH = 32
) (
    input  logic                      hclk,
    input  logic                      hreset,
    input  logic                      psel,
    input  logic                      penable,
    input  logic [PADDR_WIDTH-1:0]    paddr,
    input  logic                      pwrite,
    input  logic [APB_DATA_WIDTH-1:0] pwdata,
    output logic                      pready,
    output logic                      pslverr,
    output logic [APB_DATA_WIDTH-1:0] prdata
);
    typedef enum logic {IDLE, ACCESS} state_t;
    state_t                    state, state_nxt;
    logic [3:0]                cnt, ctrl_wait;
    logic [15:0]               ok_cnt, err_cnt;
    logic [APB_DATA_WIDTH-1:0] scratch [6];
    logic [APB_DATA_WIDTH-1:0] rdata;
    logic [2:0]                idx;
    logic                      in_range, err, setup, done, wr_en;
    assign idx      = 3'(paddr >> 2);
    assign in_range = paddr < PADDR_WIDTH'(32);
    assign err      = !in_range || (pwrite && idx == 3'd1);
    assign setup    = psel && !penable;
    assign done     = state == ACCESS && psel && penable && cnt == 4'd0;
    assign wr_en    = done && pwrite && !err;
    // state register
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) state <= IDLE;
        else        state <= state_nxt;
    end
    // next state: setup enters ACCESS; completion or a dropped psel returns to IDLE
    always_comb begin
        state_nxt = state;
        if (state == IDLE) state_nxt = setup ? ACCESS : IDLE;
        else if (!psel || done) state_nxt = IDLE;
    end
    // outputs: responses are gated so nothing leaks while pready is low
    always_comb begin
        pready  = state == ACCESS && cnt == 4'd0;
        pslverr = pready && err;
        prdata  = (pready && !pwrite && !err) ? rdata : '0;
    end
    // read mux over the register map
    always_comb begin
        rdata = idx == 3'd0 ? APB_DATA_WIDTH'(ctrl_wait) :
                idx == 3'd1 ? APB_DATA_WIDTH'({err_cnt, ok_cnt}) : scratch[idx - 3'd2];
    end
    // wait counter: loaded from CTRL at setup so a CTRL write only affects later transfers
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset)                              cnt <= 4'd0;
        else if (state == IDLE && setup)         cnt <= ctrl_wait;
        else if (state == ACCESS && cnt != 4'd0) cnt <= cnt - 4'd1;
    end
    // CTRL register, only the WAIT field is stored
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset)                      ctrl_wait <= 4'd0;
        else if (wr_en && idx == 3'd0)   ctrl_wait <= pwdata[3:0];
    end
    // scratch registers at word indices 2..7
    always_ff @(posedge hclk or posedge hreset) begin
        for (int i = 0; i < 6; i++) begin
            if (hreset)                        scratch[i] <= '0;
            else if (wr_en && idx == 3'(i + 2)) scratch[i] <= pwdata;
        end
    end
    // saturating completion counters reported in STATUS
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            ok_cnt  <= 16'd0;
            err_cnt <= 16'd0;
        end else if (done) begin
            if (err) err_cnt <= err_cnt == 16'hFFFF ? err_cnt : err_cnt + 16'd1;
            else     ok_cnt  <= ok_cnt  == 16'hFFFF ? ok_cnt  : ok_cnt  + 16'd1;
        end
    end
endmodule
